alu_ctrl: RTL and testbench

Multi-cycle initiator that drives the existing 8-bit ALU. It accepts register-register instructions over a valid/ready handshake and reads two operands from an internal register file. It presents the operands and select code to the ALU, then captures the ALU result and its Z/N/C/V flags into the register file and a status register. It sits between the instruction source (test harness or later fetch unit) and the combinational ALU.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_regfile.sv | 42 ++++
 rtl/alu_ctrl.sv | 160 ++++++++++++++++
 tb/tb_alu_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU controller slice.
//   - Opcode constants (ALU selects 0..9, LDI, CMP; 12..15 illegal)
//   - Bit positions of each flag within the {Z,N,C,V} status word
//   - Controller FSM state encoding
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOTA = 4'd5;
    localparam logic [3:0] OP_NOTB = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_INC  = 4'd9;
    localparam logic [3:0] OP_LDI  = 4'd10;
    localparam logic [3:0] OP_CMP  = 4'd11;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 2**RA_W x DATA_W register file.
// Ports:
//   clk, rst           clock and synchronous active-high reset (clears all entries)
//   i_we/i_waddr/i_wdata  single write port
//   i_raddr_a/b/dbg    three combinational read addresses
//   o_rdata_a/b/dbg    corresponding read data
module alu_regfile #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RA_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [RA_W-1:0]   i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [RA_W-1:0]   i_raddr_a,
    input  logic [RA_W-1:0]   i_raddr_b,
    input  logic [RA_W-1:0]   i_raddr_dbg,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b,
    output logic [DATA_W-1:0] o_rdata_dbg
);

    localparam int unsigned NREG = 2 ** RA_W;

    logic [DATA_W-1:0] r_mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a   = r_mem[i_raddr_a];
    assign o_rdata_b   = r_mem[i_raddr_b];
    assign o_rdata_dbg = r_mem[i_raddr_dbg];

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: multi-cycle initiator for the external combinational 8-bit ALU.
// Accepts {op, rd, rs, imm} over valid/ready, reads operands from the internal
// register file, drives registered alu_a/alu_b/alu_s, then retires the ALU
// result into R[rd] and the flags into the status register.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr_valid/ready/instr  instruction handshake (ready only in IDLE)
//   alu_a/alu_b/alu_s        registered ALU operands and select
//   alu_out, alu_z/n/c/v     ALU result and flags
//   flags                    status register {Z,N,C,V}
//   done / err               one-cycle retire / illegal-opcode pulses
//   dbg_sel / dbg_data       combinational register read-back
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RA_W   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    input  logic [4+2*RA_W+DATA_W-1:0]   instr,
    output logic [DATA_W-1:0]            alu_a,
    output logic [DATA_W-1:0]            alu_b,
    output logic [3:0]                   alu_s,
    input  logic [DATA_W-1:0]            alu_out,
    input  logic                         alu_z,
    input  logic                         alu_n,
    input  logic                         alu_c,
    input  logic                         alu_v,
    output logic [3:0]                   flags,
    output logic                         done,
    output logic                         err,
    input  logic [RA_W-1:0]              dbg_sel,
    output logic [DATA_W-1:0]            dbg_data
);

    localparam int unsigned IW = 4 + 2 * RA_W + DATA_W;

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [3:0]        r_alu_s;
    logic [RA_W-1:0]   r_rd;
    logic              r_is_cmp;
    logic [3:0]        r_flags;

    logic [3:0]        w_op;
    logic [RA_W-1:0]   w_rd;
    logic [RA_W-1:0]   w_rs;
    logic [DATA_W-1:0] w_imm;
    logic              w_xfer;
    logic              w_alu_op;
    logic [DATA_W-1:0] w_rdata_a;
    logic [DATA_W-1:0] w_rdata_b;
    logic              w_we;
    logic [RA_W-1:0]   w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [3:0]        w_alu_flags;

    assign w_op   = instr[IW-1 -: 4];
    assign w_rd   = instr[2*RA_W+DATA_W-1 -: RA_W];
    assign w_rs   = instr[RA_W+DATA_W-1 -: RA_W];
    assign w_imm  = instr[DATA_W-1:0];
    assign w_xfer = instr_valid && (r_state == IDLE);
    // CMP runs through the ALU like the pass-through selects.
    assign w_alu_op = (w_op <= OP_INC) || (w_op == OP_CMP);

    always_comb begin
        w_alu_flags         = '0;
        w_alu_flags[FLAG_Z] = alu_z;
        w_alu_flags[FLAG_N] = alu_n;
        w_alu_flags[FLAG_C] = alu_c;
        w_alu_flags[FLAG_V] = alu_v;
    end

    alu_regfile #(
        .DATA_W (DATA_W),
        .RA_W   (RA_W)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .i_we        (w_we),
        .i_waddr     (w_waddr),
        .i_wdata     (w_wdata),
        .i_raddr_a   (w_rd),
        .i_raddr_b   (w_rs),
        .i_raddr_dbg (dbg_sel),
        .o_rdata_a   (w_rdata_a),
        .o_rdata_b   (w_rdata_b),
        .o_rdata_dbg (dbg_data)
    );

    // Next state and register-file write port.
    always_comb begin
        w_state_next = r_state;
        w_we         = 1'b0;
        w_waddr      = r_rd;
        w_wdata      = alu_out;
        unique case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    if (w_op == OP_LDI) begin
                        w_we         = 1'b1;
                        w_waddr      = w_rd;
                        w_wdata      = w_imm;
                        w_state_next = DONE;
                    end else if (w_alu_op) begin
                        w_state_next = EXEC;
                    end else begin
                        w_state_next = ERR;
                    end
                end
            end
            EXEC: begin
                w_we         = !r_is_cmp;
                w_state_next = DONE;
            end
            DONE:    w_state_next = IDLE;
            ERR:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_s  <= '0;
            r_rd     <= '0;
            r_is_cmp <= 1'b0;
            r_flags  <= '0;
        end else begin
            r_state <= w_state_next;
            // LDI leaves the ALU inputs untouched.
            if (w_xfer && w_alu_op) begin
                r_alu_a  <= w_rdata_a;
                r_alu_b  <= w_rdata_b;
                r_alu_s  <= (w_op == OP_CMP) ? OP_SUB : w_op;
                r_rd     <= w_rd;
                r_is_cmp <= (w_op == OP_CMP);
            end
            if (r_state == EXEC) begin
                r_flags <= w_alu_flags;
            end
        end
    end

    assign instr_ready = (r_state == IDLE);
    assign done        = (r_state == DONE);
    assign err         = (r_state == ERR);
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_s       = r_alu_s;
    assign flags       = r_flags;

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: self-checking bench for alu_ctrl with a behavioural 8-bit ALU
// attached to the alu_* ports. Table-driven vectors cover single instructions;
// hand-written sequences cover back-to-back streaming and mid-operation reset.
module tb_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic [3:0]  alu_s;
    logic        alu_z, alu_n, alu_c, alu_v;
    logic [3:0]  flags;
    logic        done, err;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_ctrl #(
        .DATA_W (8),
        .RA_W   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_s       (alu_s),
        .alu_out     (alu_out),
        .alu_z       (alu_z),
        .alu_n       (alu_n),
        .alu_c       (alu_c),
        .alu_v       (alu_v),
        .flags       (flags),
        .done        (done),
        .err         (err),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    // Behavioural ALU: C is carry-out for ADD/INC, borrow for SUB, shifted-out bit for shifts.
    logic [8:0] alu_tmp;
    always_comb begin
        alu_tmp = '0;
        alu_out = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (alu_s)
            4'd0: begin
                alu_tmp = {1'b0, alu_a} + {1'b0, alu_b};
                alu_out = alu_tmp[7:0];
                alu_c   = alu_tmp[8];
                alu_v   = (alu_a[7] == alu_b[7]) && (alu_out[7] != alu_a[7]);
            end
            4'd1: begin
                alu_tmp = {1'b0, alu_a} - {1'b0, alu_b};
                alu_out = alu_tmp[7:0];
                alu_c   = alu_tmp[8];
                alu_v   = (alu_a[7] != alu_b[7]) && (alu_out[7] != alu_a[7]);
            end
            4'd2: alu_out = alu_a & alu_b;
            4'd3: alu_out = alu_a | alu_b;
            4'd4: alu_out = alu_a ^ alu_b;
            4'd5: alu_out = ~alu_a;
            4'd6: alu_out = ~alu_b;
            4'd7: begin
                alu_out = {alu_a[6:0], 1'b0};
                alu_c   = alu_a[7];
            end
            4'd8: begin
                alu_out = {1'b0, alu_a[7:1]};
                alu_c   = alu_a[0];
            end
            4'd9: begin
                alu_tmp = {1'b0, alu_a} + 9'd1;
                alu_out = alu_tmp[7:0];
                alu_c   = alu_tmp[8];
                alu_v   = !alu_a[7] && alu_out[7];
            end
            default: alu_out = '0;
        endcase
        alu_z = (alu_out == 8'h00);
        alu_n = alu_out[7];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offers one instruction, then returns in the cycle done or err is seen.
    // lat = 1 means the pulse appeared in the cycle right after the transfer edge.
    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [7:0] imm, output int lat);
        int w = 0;
        while (!instr_ready && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        if (!instr_ready) check("ready_wait_timeout", 32'd0, 32'd1);
        instr_valid = 1'b1;
        instr       = {op, rd, rs, imm};
        @(posedge clk); #1;
        instr_valid = 1'b0;
        lat = 1;
        while (!(done || err) && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] imm;
        logic [1:0] chk;
        logic [7:0] exp_data;
        logic [3:0] exp_flags;
        logic       exp_err;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    initial begin
        int lat;
        int exp_lat;
        int xfers, readies, dones, exp_r0;
        logic saw_done;

        // op, rd, rs, imm, chk reg, expected R[chk], expected flags {Z,N,C,V}, expected err
        vecs[0]  = '{4'hA, 2'd0, 2'd0, 8'h7F, 2'd0, 8'h7F, 4'b0000, 1'b0};
        vecs[1]  = '{4'hA, 2'd1, 2'd0, 8'h01, 2'd1, 8'h01, 4'b0000, 1'b0};
        vecs[2]  = '{4'h0, 2'd0, 2'd1, 8'h00, 2'd0, 8'h80, 4'b0101, 1'b0};  // ADD overflow
        vecs[3]  = '{4'hA, 2'd2, 2'd0, 8'h55, 2'd2, 8'h55, 4'b0101, 1'b0};
        vecs[4]  = '{4'hA, 2'd3, 2'd0, 8'h55, 2'd3, 8'h55, 4'b0101, 1'b0};
        vecs[5]  = '{4'hB, 2'd2, 2'd3, 8'h00, 2'd2, 8'h55, 4'b1000, 1'b0};  // CMP equal
        vecs[6]  = '{4'hA, 2'd0, 2'd0, 8'hFF, 2'd0, 8'hFF, 4'b1000, 1'b0};
        vecs[7]  = '{4'h9, 2'd0, 2'd0, 8'h00, 2'd0, 8'h00, 4'b1010, 1'b0};  // INC wrap
        vecs[8]  = '{4'hA, 2'd0, 2'd0, 8'h81, 2'd0, 8'h81, 4'b1010, 1'b0};
        vecs[9]  = '{4'h8, 2'd0, 2'd0, 8'h00, 2'd0, 8'h40, 4'b0010, 1'b0};  // SHR
        vecs[10] = '{4'hA, 2'd1, 2'd0, 8'h7F, 2'd1, 8'h7F, 4'b0010, 1'b0};
        vecs[11] = '{4'hA, 2'd2, 2'd0, 8'h01, 2'd2, 8'h01, 4'b0010, 1'b0};
        vecs[12] = '{4'h0, 2'd1, 2'd2, 8'h00, 2'd1, 8'h80, 4'b0101, 1'b0};
        vecs[13] = '{4'hC, 2'd1, 2'd2, 8'h33, 2'd1, 8'h80, 4'b0101, 1'b1};  // illegal
        vecs[14] = '{4'hF, 2'd0, 2'd0, 8'h33, 2'd0, 8'h40, 4'b0101, 1'b1};  // illegal
        vecs[15] = '{4'hA, 2'd3, 2'd0, 8'h10, 2'd3, 8'h10, 4'b0101, 1'b0};
        vecs[16] = '{4'h1, 2'd0, 2'd3, 8'h00, 2'd0, 8'h30, 4'b0000, 1'b0};  // SUB
        vecs[17] = '{4'h4, 2'd0, 2'd1, 8'h00, 2'd0, 8'hB0, 4'b0100, 1'b0};  // XOR
        vecs[18] = '{4'h1, 2'd3, 2'd1, 8'h00, 2'd3, 8'h90, 4'b0111, 1'b0};  // SUB borrow+ovf
        vecs[19] = '{4'h2, 2'd0, 2'd3, 8'h00, 2'd0, 8'h90, 4'b0100, 1'b0};  // AND
        vecs[20] = '{4'h6, 2'd2, 2'd0, 8'h00, 2'd2, 8'h6F, 4'b0000, 1'b0};  // NOTB
        vecs[21] = '{4'h7, 2'd3, 2'd3, 8'h00, 2'd3, 8'h20, 4'b0010, 1'b0};  // SHL, rd==rs

        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        dbg_sel     = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_err",   {31'd0, err}, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_alu",   {12'd0, alu_a, alu_b, alu_s}, 32'd0);
        for (int r = 0; r < 4; r++) begin
            dbg_sel = 2'(r);
            #1;
            check("rst_reg", {24'd0, dbg_data}, 32'd0);
        end

        // Table-driven single instructions
        for (int i = 0; i < NV; i++) begin
            dbg_sel = vecs[i].chk;
            issue(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm, lat);
            exp_lat = (vecs[i].exp_err || vecs[i].op == 4'hA) ? 1 : 2;
            check($sformatf("v%0d_latency", i), lat, exp_lat);
            check($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            check($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, !vecs[i].exp_err});
            check($sformatf("v%0d_reg", i), {24'd0, dbg_data}, {24'd0, vecs[i].exp_data});
            check($sformatf("v%0d_flags", i), {28'd0, flags}, {28'd0, vecs[i].exp_flags});
            step();
            check($sformatf("v%0d_pulse_end", i), {30'd0, done, err}, 32'd0);
            check($sformatf("v%0d_ready", i), {31'd0, instr_ready}, 32'd1);
        end

        // Back-to-back ADD R0 += R1 with instr_valid held high
        issue(4'hA, 2'd0, 2'd0, 8'h01, lat);
        step();
        issue(4'hA, 2'd1, 2'd0, 8'h03, lat);
        step();
        dbg_sel     = 2'd0;
        instr       = {4'h0, 2'd0, 2'd1, 8'h00};
        instr_valid = 1'b1;
        xfers = 0; readies = 0; dones = 0; exp_r0 = 1;
        for (int c = 0; c < 12; c++) begin
            if (instr_ready && instr_valid) xfers++;
            if (instr_ready) readies++;
            if (done) begin
                dones++;
                exp_r0 = exp_r0 + 3;
                check("stream_result", {24'd0, dbg_data}, exp_r0);
            end
            if (c == 11) instr_valid = 1'b0;
            step();
        end
        check("stream_xfers",   xfers, 4);
        check("stream_readies", readies, 4);
        check("stream_dones",   dones, 4);
        check("stream_final",   {24'd0, dbg_data}, 32'h0D);

        // Reset during EXEC of ADD R0 <- 0x10 + 0x20
        issue(4'hA, 2'd0, 2'd0, 8'h10, lat);
        step();
        issue(4'hA, 2'd1, 2'd0, 8'h20, lat);
        step();
        instr       = {4'h0, 2'd0, 2'd1, 8'h00};
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        check("mid_rst_exec_ready", {31'd0, instr_ready}, 32'd0);
        rst = 1'b1;
        step();
        check("mid_rst_done", {30'd0, done, err}, 32'd0);
        instr_valid = 1'b1;  // reset must win over this offer
        step();
        rst         = 1'b0;
        instr_valid = 1'b0;
        saw_done    = 1'b0;
        step();
        check("post_rst_ready", {31'd0, instr_ready}, 32'd1);
        check("post_rst_flags", {28'd0, flags}, 32'd0);
        dbg_sel = 2'd0;
        #1;
        check("post_rst_r0", {24'd0, dbg_data}, 32'd0);
        dbg_sel = 2'd1;
        #1;
        check("post_rst_r1", {24'd0, dbg_data}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            if (done || err) saw_done = 1'b1;
            step();
        end
        check("post_rst_no_pulse", {31'd0, saw_done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
